// File: rtl/kv_refill_arbiter.sv
// rtl/kv_refill_arbiter.sv - round-robin line-fetch arbiter between the I-side and D-side KV caches.
// Optional response watchdog and sticky o_timeout: define KV_REFILL_TIMEOUT_EN.
module kv_refill_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 4,
`ifdef KV_REFILL_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 255,
`endif
  localparam int LINE_WIDTH = DATA_WIDTH * LINE_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  output logic [LINE_WIDTH-1:0] o_resp0_data,
  output logic                  o_resp0_valid,
  input  logic                  i_resp0_ready,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  output logic [LINE_WIDTH-1:0] o_resp1_data,
  output logic                  o_resp1_valid,
  input  logic                  i_resp1_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_addr_valid,
  input  logic                  i_mem_addr_ready,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_data_valid,
  output logic                  o_mem_data_ready,
  output logic                  o_busy
`ifdef KV_REFILL_TIMEOUT_EN
  ,
  output logic                  o_timeout
`endif
);

  localparam int OFFSET_BITS = $clog2(LINE_SIZE) + $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  grant0, grant1, resp_ready;

`ifdef KV_REFILL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  assign o_timeout = timeout_q;
`endif

  // On a tie the requester that was not served last wins.
  assign grant0 = i_req0_valid & (~i_req1_valid | last_grant_q);
  assign grant1 = i_req1_valid & (~i_req0_valid | ~last_grant_q);

  assign o_req0_ready     = (state_q == S_IDLE) & grant0;
  assign o_req1_ready     = (state_q == S_IDLE) & grant1;
  assign o_mem_addr       = addr_q;
  assign o_mem_addr_valid = (state_q == S_ISSUE);
  assign o_mem_data_ready = (state_q == S_WAIT);
  assign o_resp0_valid    = (state_q == S_DELIVER) & ~owner_q;
  assign o_resp1_valid    = (state_q == S_DELIVER) & owner_q;
  assign o_resp0_data     = line_q;
  assign o_resp1_data     = line_q;
  assign o_busy           = (state_q != S_IDLE);
  assign resp_ready       = owner_q ? i_resp1_ready : i_resp0_ready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    line_d       = line_q;
`ifdef KV_REFILL_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant0 | grant1) begin
          owner_d = grant1;
          addr_d  = (grant1 ? i_req1_addr : i_req0_addr) & ADDR_MASK;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_mem_addr_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_data_valid) begin
          line_d  = i_mem_data;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (resp_ready) begin
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef KV_REFILL_TIMEOUT_EN
    // Counter restarts on every state entry, so ISSUE and WAIT each get the full budget.
    if ((state_q == S_ISSUE || state_q == S_WAIT) && state_d == state_q) begin
      if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
      end
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
    if (state_d != state_q) tmo_cnt_d = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      line_q       <= '0;
`ifdef KV_REFILL_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
`ifdef KV_REFILL_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_kv_refill_arbiter.sv
// tb/tb_kv_refill_arbiter.sv - scoreboard bench for kv_refill_arbiter.
// Timeout scenario is built only when KV_REFILL_TIMEOUT_EN is defined.
module tb_kv_refill_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  typedef struct {
    logic          owner;
    logic [LW-1:0] line;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] req0_addr, req1_addr, mem_addr;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [LW-1:0] resp0_data, resp1_data, mem_data;
  logic resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic mem_addr_valid, mem_addr_ready, mem_data_valid, mem_data_ready, busy;
`ifdef KV_REFILL_TIMEOUT_EN
  logic timeout;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  kv_refill_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(4)
`ifdef KV_REFILL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_addr(req0_addr), .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .o_resp0_data(resp0_data), .o_resp0_valid(resp0_valid), .i_resp0_ready(resp0_ready),
    .i_req1_addr(req1_addr), .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .o_resp1_data(resp1_data), .o_resp1_valid(resp1_valid), .i_resp1_ready(resp1_ready),
    .o_mem_addr(mem_addr), .o_mem_addr_valid(mem_addr_valid), .i_mem_addr_ready(mem_addr_ready),
    .i_mem_data(mem_data), .i_mem_data_valid(mem_data_valid), .o_mem_data_ready(mem_data_ready),
    .o_busy(busy)
`ifdef KV_REFILL_TIMEOUT_EN
    , .o_timeout(timeout)
`endif
  );

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {a ^ 32'hDDDD_DDDD, a ^ 32'hCCCC_CCCC, a ^ 32'hBBBB_BBBB, a ^ 32'hAAAA_AAAA};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
    resp0_ready = 0; resp1_ready = 0; mem_addr_ready = 0;
    mem_data_valid = 0; mem_data = '0;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, mem_addr_valid, mem_data_ready, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, mem_addr_valid, mem_data_ready, busy});
    end
    n_cmp++;
    if ({mem_addr, resp0_data, resp1_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr %h resp0 %h resp1 %h want 0", mem_addr, resp0_data, resp1_data);
    end
    step();
  endtask

  task automatic test_single();
    exp_t e;
    logic [LW-1:0] line;
    do_reset();
    line = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    req0_addr = 32'h0000_1234; req0_valid = 1; mem_addr_ready = 1; resp0_ready = 1; resp1_ready = 1;
    sb.push_back('{owner: 1'b0, line: line});
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL single_accept: got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr_valid, mem_addr} !== {1'b1, 32'h0000_1230}) begin
      n_bad++; $display("FAIL single_issue: got %b/%h want 1/00001230", mem_addr_valid, mem_addr);
    end
    step();
    mem_data = line; mem_data_valid = 1;
    @(negedge clk);
    n_cmp++;
    if (mem_data_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_wait: mem_data_ready got %b want 1", mem_data_ready);
    end
    step();
    mem_data_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({resp0_valid, resp1_valid} !== 2'b10) begin
      n_bad++; $display("FAIL single_resp_valid: got %b want 10", {resp0_valid, resp1_valid});
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL single_sb: scoreboard empty got 0 want 1");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (resp0_data !== e.line) begin
        n_bad++; $display("FAIL single_resp_data: got %h want %h", resp0_data, e.line);
      end
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin
      n_bad++; $display("FAIL single_idle: got %b want 000", {busy, resp0_valid, resp1_valid});
    end
    step();
  endtask

  task automatic test_tie_alternate();
    exp_t e;
    logic exp_owner;
    logic [AW-1:0] masked, issued;
    do_reset();
    req0_valid = 1; req1_valid = 1; mem_addr_ready = 1; resp0_ready = 1; resp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      req0_addr = 32'h0000_0100 + 32'(k * 64) + 32'h5;
      req1_addr = 32'h0000_2008 + 32'(k * 64);
      exp_owner = (k % 2 == 1);
      masked = (exp_owner ? req1_addr : req0_addr) & 32'hFFFF_FFF0;
      sb.push_back('{owner: exp_owner, line: mem_line(masked)});
      @(negedge clk);
      n_cmp++;
      if ({req1_ready, req0_ready} !== (exp_owner ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL tie_grant%0d: got %b want %b", k, {req1_ready, req0_ready},
                          (exp_owner ? 2'b10 : 2'b01));
      end
      step();
      @(negedge clk);
      issued = mem_addr;
      n_cmp++;
      if (mem_addr !== masked) begin
        n_bad++; $display("FAIL tie_addr%0d: got %h want %h", k, mem_addr, masked);
      end
      step();
      mem_data = mem_line(issued); mem_data_valid = 1;
      step();
      mem_data_valid = 0;
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL tie_sb%0d: scoreboard empty got 0 want 1", k);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if ({resp1_valid, resp0_valid} !== (e.owner ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL tie_resp_valid%0d: got %b want owner %0d", k, {resp1_valid, resp0_valid}, e.owner);
        end
        n_cmp++;
        if ((e.owner ? resp1_data : resp0_data) !== e.line) begin
          n_bad++; $display("FAIL tie_resp_data%0d: got %h want %h", k, (e.owner ? resp1_data : resp0_data), e.line);
        end
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_mem_backpressure();
    exp_t e;
    do_reset();
    req1_addr = 32'h4444_567C; req1_valid = 1; mem_addr_ready = 0; resp1_ready = 1;
    sb.push_back('{owner: 1'b1, line: mem_line(32'h4444_5670)});
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_accept: got %b want 1", req1_ready);
    end
    step();
    req1_valid = 0; mem_data = '1; mem_data_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_addr_valid, mem_addr, mem_data_ready} !== {1'b1, 32'h4444_5670, 1'b0}) begin
        n_bad++; $display("FAIL bp_hold%0d: got %b/%h/%b want 1/44445670/0", i, mem_addr_valid, mem_addr, mem_data_ready);
      end
      step();
    end
    mem_addr_ready = 1; mem_data_valid = 0;
    step();
    mem_addr_ready = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr_valid, mem_data_ready} !== 2'b01) begin
      n_bad++; $display("FAIL bp_wait: got %b want 01", {mem_addr_valid, mem_data_ready});
    end
    mem_data = mem_line(32'h4444_5670); mem_data_valid = 1;
    step();
    mem_data_valid = 0;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL bp_sb: scoreboard empty got 0 want 1");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({resp1_valid, resp0_valid, resp1_data} !== {1'b1, 1'b0, e.line}) begin
        n_bad++; $display("FAIL bp_resp: got %b%b %h want 10 %h", resp1_valid, resp0_valid, resp1_data, e.line);
      end
    end
    step();
  endtask

  task automatic test_consumer_backpressure();
    exp_t e;
    logic [AW-1:0] issued;
    do_reset();
    req1_addr = 32'h0000_8008; req1_valid = 1; mem_addr_ready = 1; resp1_ready = 0;
    sb.push_back('{owner: 1'b1, line: mem_line(32'h0000_8000)});
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_bad++; $display("FAIL cbp_accept: got %b want 1", req1_ready);
    end
    step();
    req1_valid = 0; req0_valid = 1; req0_addr = 32'h0000_9000;
    @(negedge clk);
    issued = mem_addr;
    step();
    mem_data = mem_line(issued); mem_data_valid = 1;
    step();
    mem_data_valid = 0;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL cbp_sb: scoreboard empty got 0 want 1");
      e = '{owner: 1'b1, line: '0};
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({resp1_valid, resp1_data, req0_ready} !== {1'b1, e.line, 1'b0}) begin
        n_bad++; $display("FAIL cbp_hold%0d: got %b %h req0_ready %b want 1 %h 0", i, resp1_valid, resp1_data, req0_ready, e.line);
      end
      step();
    end
    resp1_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({resp1_valid, req0_ready} !== 2'b10) begin
      n_bad++; $display("FAIL cbp_release: got %b want 10", {resp1_valid, req0_ready});
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({busy, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL cbp_idle: got %b want 01", {busy, req0_ready});
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req0_addr = 32'h2222_0004; req0_valid = 1; mem_addr_ready = 1; resp0_ready = 1;
    step();
    req0_valid = 0;
    step();
    @(negedge clk);
    n_cmp++;
    if (mem_data_ready !== 1'b1) begin
      n_bad++; $display("FAIL rmw_in_wait: got %b want 1", mem_data_ready);
    end
    rst = 1;
    step();
    rst = 0;
    mem_data = mem_line(32'h2222_0000); mem_data_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({resp0_valid, resp1_valid, busy, mem_addr_valid, mem_data_ready, req0_ready, req1_ready} !== 7'b0) begin
        n_bad++; $display("FAIL rmw_ctrl%0d: got %b want 0000000", i,
                          {resp0_valid, resp1_valid, busy, mem_addr_valid, mem_data_ready, req0_ready, req1_ready});
      end
      n_cmp++;
      if ({mem_addr, resp0_data} !== '0) begin
        n_bad++; $display("FAIL rmw_data%0d: addr %h resp0 %h want 0", i, mem_addr, resp0_data);
      end
      step();
    end
    mem_data_valid = 0;
  endtask

`ifdef KV_REFILL_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req0_addr = 32'h0000_3330; req0_valid = 1; mem_addr_ready = 1; resp0_ready = 1;
    step();
    req0_valid = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, mem_data_ready, timeout} !== 3'b110) begin
        n_bad++; $display("FAIL tmo_wait%0d: got %b want 110", i, {busy, mem_data_ready, timeout});
      end
      step();
    end
    req0_valid = 1;
    @(negedge clk);
    n_cmp++;
    if ({busy, timeout, req0_ready, resp0_valid} !== 4'b0110) begin
      n_bad++; $display("FAIL tmo_expire: got %b want 0110", {busy, timeout, req0_ready, resp0_valid});
    end
    step();
    req0_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr_valid, timeout} !== 2'b11) begin
      n_bad++; $display("FAIL tmo_rerequest: got %b want 11", {mem_addr_valid, timeout});
    end
    step();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_tie_alternate();
    test_mem_backpressure();
    test_consumer_backpressure();
    test_reset_mid_wait();
`ifdef KV_REFILL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
